sc_mult_sequencer: RTL and testbench
====================================

Name: sc_mult_sequencer

Overview:
Sequences one stochastic multiplication on the team's AND-gate stochastic multiplier. Converts two 8-bit binary operands into unipolar bitstreams using LFSR comparators and drives them to the multiplier for a programmable stream length. Counts the ones in the returned product stream and reports the count as the binary result. Sits between the binary control side and the combinational stochastic multiplier.

Parameters:
LEN_W, 9, width of stream length, cycle counter and ones counter; max stream length 2^LEN_W-1
SEED_A, 8'h01, reset/start seed of LFSR A; must be nonzero
SEED_B, 8'hA5, start seed of LFSR B; used only with SC_DECORR_EN; must be nonzero

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request a multiplication; sampled only in IDLE
op_a  in  8  operand A; probability op_a/256
op_b  in  8  operand B; probability op_b/256
nummax  in  LEN_W  stream length in cycles; latched at start
sa  out  1  bitstream A to the multiplier
sb  out  1  bitstream B to the multiplier
stream_valid  out  1  high while sa/sb carry a live stream (RUN)
sc  in  1  product bitstream returned from the multiplier; combinational in the same cycle as sa/sb
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse when result becomes valid
result  out  LEN_W  count of ones in sc over the stream; held until the next accepted start

Behaviour:
- Reset: FSM=IDLE, lfsr_a=SEED_A, lfsr_b=SEED_B, counters=0, result=0, done=0, busy=0, stream_valid=0, sa=sb=0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 and nummax!=0: latch op_a, op_b, nummax; load lfsr_a=SEED_A (and lfsr_b=SEED_B); clear cyc and ones; next state RUN.
- IDLE with start=1 and nummax==0: result<=0; next state DONE. No stream is generated.
- RUN, every cycle: stream_valid=1. sa=(lfsr_a < op_a_l) and sb=(lfsr_x < op_b_l), both combinational from registered state. If sc=1, ones increments. LFSRs advance and cyc increments.
- LFSR: 8-bit Fibonacci, next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. Period 255; values 1..255; 0 never occurs.
- Comparator consequences: op=0 gives a constant 0 stream. op=255 is low only when the LFSR value is 255.
- RUN exit: in the cycle where cyc==nummax_l-1, result<=ones+sc and next state DONE. RUN therefore lasts exactly nummax_l cycles.
- DONE: done=1 for one cycle, busy=1, stream_valid=0, sa=sb=0; next state IDLE.
- Latency: start accepted in cycle 0; RUN in cycles 1..N; done in cycle N+1. Next start is accepted in cycle N+2 at the earliest.
- start while busy is ignored; it is not queued.
- Operand and nummax changes during RUN are ignored because the values are latched.
- nummax>255 reuses the LFSR sequence periodically without reseeding.
- result saturation cannot occur: ones<=nummax_l<=2^LEN_W-1.
- rst mid-operation aborts immediately to reset values. No done pulse is generated; result clears to 0.

Optional Feature:
SC_DECORR_EN
- Defined: sb compares against independent lfsr_b (seeded SEED_B at start, same polynomial, advanced in lockstep with lfsr_a).
- Undefined: lfsr_b is not implemented. sb compares against bit-reversed lfsr_a, which saves 8 flops but correlates the streams.

Test Plan:
- Bench loopback sc=sa&sb. op_a=0, op_b=200, nummax=255, start -> done in cycle 256 after the start cycle; result=0.
- op_a=255, op_b=255, nummax=255, SC_DECORR_EN undefined -> result=254. Both streams are low in the same cycle, since reverse(255)=255.
- Same stimulus with SC_DECORR_EN defined -> result=253, because the low cycles are distinct.
- op_a=128, op_b=255, nummax=255, undefined -> result=127. sa is high for LFSR values 1..127, and sb is low only at 255.
- nummax=0, start -> done exactly one cycle later, result=0, stream_valid never asserted.
- Start op_a=op_b=255, nummax=100; assert rst at RUN cycle 50 -> busy=0, result=0, no done. A new start of the same job afterwards produces the same result as an uninterrupted run, and a start pulse during RUN has no effect.

Source files
------------

// File: rtl/sc_mult_sequencer.sv
// sc_mult_sequencer: turns two 8-bit operands into LFSR-compared unipolar streams, drives the AND multiplier for nummax cycles and counts the ones in the product stream
//   ports: clk, rst (sync, active-high); start, op_a, op_b, nummax in; sa, sb, stream_valid out to the multiplier; sc product in;
//   busy, done (one-cycle pulse), result (ones count) out. Optional macro SC_DECORR_EN adds an independent LFSR B for sb.
module sc_mult_sequencer #(
  parameter int         LEN_W  = 9,
  parameter logic [7:0] SEED_A = 8'h01,
  parameter logic [7:0] SEED_B = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  input  logic [LEN_W-1:0] nummax,
  output logic             sa,
  output logic             sb,
  output logic             stream_valid,
  input  logic             sc,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       lfsr_a_q, lfsr_a_d, op_a_q, op_a_d, op_b_q, op_b_d, lfsr_x;
  logic [LEN_W-1:0] nummax_q, nummax_d, cyc_q, cyc_d, ones_q, ones_d, result_q, result_d;
  if (SEED_A == 8'h00 || SEED_B == 8'h00) begin : g_seed_chk
    $error("LFSR seeds must be nonzero");
  end
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
`ifdef SC_DECORR_EN
  logic [7:0] lfsr_b_q, lfsr_b_d;
  assign lfsr_x = lfsr_b_q;
  always_comb lfsr_b_d = (state_q == IDLE && start) ? SEED_B : (state_q == RUN) ? lfsr_next(lfsr_b_q) : lfsr_b_q;
  always_ff @(posedge clk) lfsr_b_q <= rst ? SEED_B : lfsr_b_d;
`else
  // bit-reversed lfsr_a stands in for a second generator; cheaper but correlated with sa
  always_comb for (int i = 0; i < 8; i++) lfsr_x[i] = lfsr_a_q[7-i];
`endif
  assign stream_valid = state_q == RUN;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign sa           = stream_valid && (lfsr_a_q < op_a_q);
  assign sb           = stream_valid && (lfsr_x < op_b_q);
  assign result       = result_q;
  always_comb begin
    state_d  = state_q;
    lfsr_a_d = lfsr_a_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    nummax_d = nummax_q;
    cyc_d    = cyc_q;
    ones_d   = ones_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        result_d = '0;
        state_d  = (nummax != '0) ? RUN : DONE;
        if (nummax != '0) begin
          op_a_d   = op_a;
          op_b_d   = op_b;
          nummax_d = nummax;
          lfsr_a_d = SEED_A;
          cyc_d    = '0;
          ones_d   = '0;
        end
      end
      RUN: begin
        ones_d   = ones_q + LEN_W'(sc);
        lfsr_a_d = lfsr_next(lfsr_a_q);
        cyc_d    = cyc_q + 1'b1;
        if (cyc_q == nummax_q - 1'b1) begin
          result_d = ones_d;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_a_q <= SEED_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      nummax_q <= '0;
      cyc_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_a_q <= lfsr_a_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      nummax_q <= nummax_d;
      cyc_q    <= cyc_d;
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_sc_mult_sequencer.sv
// tb_sc_mult_sequencer: directed self-checking bench with an AND-gate loopback multiplier
module tb_sc_mult_sequencer;
  localparam int LEN_W = 9;
  logic             clk = 0, rst = 1, start = 0, sc;
  logic [7:0]       op_a = 0, op_b = 0;
  logic [LEN_W-1:0] nummax = 0, result;
  logic             sa, sb, stream_valid, busy, done;
  int               passed = 0, total = 0;
  int               lat, svc, bc, dcnt;
  logic [LEN_W-1:0] res, held;

  sc_mult_sequencer #(.LEN_W(LEN_W), .SEED_A(8'h01), .SEED_B(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .nummax(nummax),
    .sa(sa), .sb(sb), .stream_valid(stream_valid), .sc(sc),
    .busy(busy), .done(done), .result(result)
  );
  assign sc = sa & sb;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int model(input int a, input int b, input int n);
    logic [7:0] la = 8'h01, lb = 8'hA5, x;
    int c = 0;
    for (int i = 0; i < n; i++) begin
`ifdef SC_DECORR_EN
      x = lb;
`else
      for (int k = 0; k < 8; k++) x[k] = la[7-k];
`endif
      c += (int'(la) < a && int'(x) < b) ? 1 : 0;
      la = nxt(la);
      lb = nxt(lb);
    end
    return c;
  endfunction

  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [LEN_W-1:0] n, input int poke,
                         output logic [LEN_W-1:0] r, output int l, output int s, output int bsy);
    @(negedge clk);
    op_a = a; op_b = b; nummax = n; start = 1;
    @(posedge clk); #1 start = 0;
    l = 1; s = 0; bsy = 0;
    while (!done && l < 2000) begin
      s += int'(stream_valid);
      bsy += int'(busy);
      if (l == poke) begin
        start = 1; op_a = 8'd0; op_b = 8'd0; nummax = 9'd3;
      end
      @(posedge clk); #1 start = 0; op_a = a; op_b = b; nummax = n;
      l++;
    end
    bsy += int'(busy);
    r = result;
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sv", int'(stream_valid), 0);
    chk("rst_sa_sb", int'({sa, sb}), 0);
    chk("rst_result", int'(result), 0);
    rst = 0;

    run_job(8'd0, 8'd200, 9'd255, 0, res, lat, svc, bc);
    chk("opa0_result", int'(res), 0);
    chk("opa0_latency", lat, 256);
    chk("opa0_sv_cycles", svc, 255);
    chk("opa0_busy_cycles", bc, 256);

    run_job(8'd255, 8'd255, 9'd255, 0, res, lat, svc, bc);
`ifdef SC_DECORR_EN
    chk("full_result", int'(res), 253);
`else
    chk("full_result", int'(res), 254);
`endif
    chk("full_latency", lat, 256);

    run_job(8'd128, 8'd255, 9'd255, 0, res, lat, svc, bc);
`ifdef SC_DECORR_EN
    chk("half_result", int'(res), model(128, 255, 255));
`else
    chk("half_result", int'(res), 127);
`endif

    run_job(8'd77, 8'd99, 9'd0, 0, res, lat, svc, bc);
    chk("zero_result", int'(res), 0);
    chk("zero_latency", lat, 1);
    chk("zero_sv_cycles", svc, 0);
    chk("zero_busy_cycles", bc, 1);

    run_job(8'd100, 8'd50, 9'd300, 0, res, lat, svc, bc);
    chk("long_result", int'(res), model(100, 50, 300));
    chk("long_latency", lat, 301);
    chk("long_sv_cycles", svc, 300);
    held = res;
    repeat (5) @(posedge clk);
    #1;
    chk("result_held", int'(result), int'(held));

    @(negedge clk);
    op_a = 8'd255; op_b = 8'd255; nummax = 9'd100; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (49) @(posedge clk);
    #1;
    chk("abort_pre_busy", int'(busy), 1);
    chk("abort_pre_sv", int'(stream_valid), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_sv", int'(stream_valid), 0);
    rst = 0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      dcnt += int'(done);
      @(posedge clk); #1;
    end
    chk("abort_no_done", dcnt, 0);

    run_job(8'd255, 8'd255, 9'd100, 40, res, lat, svc, bc);
    chk("rerun_result", int'(res), model(255, 255, 100));
    chk("rerun_latency", lat, 101);
    chk("rerun_sv_cycles", svc, 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
